// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: SEQ Y86-64 fetch stage holding the PC register,
// the byte-addressed instruction memory and the processor status.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load_en/addr/data   program-load byte write (stalls the PC)
//   pc_updated          next PC from the PC-update stage
//   pc                  current PC register
//   icode, ifun         opcode nibbles of the byte at pc
//   rA, rB              register specifiers (4'hF when absent)
//   valC, valP          constant word and fall-through PC
//   instr_valid         icode/ifun combination is legal
//   imem_error          instruction extends past the end of memory
//   stat, halted        status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   instr_count         instructions retired since reset
module fetch_pc_reg #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [7:0]  load_data,
    input  logic [63:0] pc_updated,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] instr_count
);

    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] MEM_SIZE = 64'(IMEM_BYTES);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    logic [7:0]  mem_q [IMEM_BYTES];
    logic [63:0] pc_q, pc_d;
    logic [63:0] cnt_q, cnt_d;
    stat_e       stat_q, stat_d;

    logic [63:0] rd_addr [10];
    logic [7:0]  ib [10];

    logic [3:0]  icode_w;
    logic [3:0]  ifun_w;
    logic        valid_w;
    logic [3:0]  len_w;
    logic        has_reg;
    logic        c_at1;
    logic        c_at2;
    logic [63:0] valc_w;
    logic        err_w;

    // Byte window pc..pc+9; anything past the end of memory reads as zero.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            rd_addr[k] = pc_q + 64'(k);
            ib[k] = (rd_addr[k] < MEM_SIZE) ?
                    mem_q[rd_addr[k][AW-1:0]] : 8'h00;
        end
    end

    always_comb begin
        icode_w = ib[0][7:4];
        ifun_w  = ib[0][3:0];
        valid_w = 1'b0;
        len_w   = 4'd1;
        has_reg = 1'b0;
        c_at1   = 1'b0;
        c_at2   = 1'b0;
        case (icode_w)
            4'h0, 4'h1:       valid_w = (ifun_w == 4'h0);
            4'h2, 4'h7:       valid_w = (ifun_w <= 4'h6);
            4'h6:             valid_w = (ifun_w <= 4'h3);
            4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA,
            4'hB:             valid_w = (ifun_w == 4'h0);
            default:          valid_w = 1'b0;
        endcase
        case (icode_w)
            4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:          has_reg = 1'b0;
        endcase
        case (icode_w)
            4'h3, 4'h4, 4'h5: c_at2 = 1'b1;
            4'h7, 4'h8:       c_at1 = 1'b1;
            default:          ;
        endcase
        if (valid_w) begin
            case (icode_w)
                4'h2, 4'h6,
                4'hA, 4'hB:       len_w = 4'd2;
                4'h3, 4'h4, 4'h5: len_w = 4'd10;
                4'h7, 4'h8:       len_w = 4'd9;
                default:          len_w = 4'd1;
            endcase
        end
    end

    always_comb begin
        valc_w = 64'h0;
        if (c_at2) begin
            valc_w = {ib[9], ib[8], ib[7], ib[6],
                      ib[5], ib[4], ib[3], ib[2]};
        end else if (c_at1) begin
            valc_w = {ib[8], ib[7], ib[6], ib[5],
                      ib[4], ib[3], ib[2], ib[1]};
        end
    end

    // 65-bit sum so a window that wraps past 2^64 still counts as out of range.
    assign err_w = ({1'b0, pc_q} + 65'(len_w)) > {1'b0, MEM_SIZE};

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        stat_d = stat_q;
        if (reset) begin
            pc_d   = 64'h0;
            cnt_d  = 64'h0;
            stat_d = STAT_AOK;
        end else if (!load_en && stat_q == STAT_AOK) begin
            if (err_w) begin
                stat_d = STAT_ADR;
            end else if (!valid_w) begin
                stat_d = STAT_INS;
            end else if (icode_w == 4'h0) begin
                stat_d = STAT_HLT;
                cnt_d  = cnt_q + 64'd1;
            end else begin
                pc_d  = pc_updated;
                cnt_d = cnt_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        cnt_q  <= cnt_d;
        stat_q <= stat_d;
    end

    // Program load ignores reset and status; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (load_en && load_addr < MEM_SIZE) begin
            mem_q[load_addr[AW-1:0]] <= load_data;
        end
    end

    assign pc          = pc_q;
    assign icode       = icode_w;
    assign ifun        = ifun_w;
    assign rA          = has_reg ? ib[1][7:4] : 4'hF;
    assign rB          = has_reg ? ib[1][3:0] : 4'hF;
    assign valC        = valc_w;
    assign valP        = pc_q + {60'h0, len_w};
    assign instr_valid = valid_w;
    assign imem_error  = err_w;
    assign stat        = stat_q;
    assign halted      = (stat_q != STAT_AOK);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_reg.sv
// tb_fetch_pc_reg: directed scoreboard bench for fetch_pc_reg.
// Stimulus queues expected state; a negedge monitor compares it.
module tb_fetch_pc_reg;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [63:0] load_addr;
    logic [7:0]  load_data;
    logic [63:0] pc_updated;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instr_count;

    fetch_pc_reg #(.IMEM_BYTES(1024)) dut (
        .clk(clk),
        .reset(reset),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .pc_updated(pc_updated),
        .pc(pc),
        .icode(icode),
        .ifun(ifun),
        .rA(rA),
        .rB(rB),
        .valC(valC),
        .valP(valP),
        .instr_valid(instr_valid),
        .imem_error(imem_error),
        .stat(stat),
        .halted(halted),
        .instr_count(instr_count)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        vld;
        logic        err;
        logic [2:0]  stat;
        logic        halted;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] a, input logic [7:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic expect_state(
        input int id,
        input logic [63:0] e_pc, input logic [3:0] e_ic,
        input logic [3:0] e_if, input logic [3:0] e_ra,
        input logic [3:0] e_rb, input logic [63:0] e_vc,
        input logic [63:0] e_vp, input logic e_vld,
        input logic e_err, input logic [2:0] e_st,
        input logic e_h, input logic [63:0] e_cnt);
        exp_t e;
        e.pc = e_pc;
        e.icode = e_ic;
        e.ifun = e_if;
        e.ra = e_ra;
        e.rb = e_rb;
        e.valc = e_vc;
        e.valp = e_vp;
        e.vld = e_vld;
        e.err = e_err;
        e.stat = e_st;
        e.halted = e_h;
        e.cnt = e_cnt;
        sb_q.push_back(e);
        tag_q.push_back(id);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h",
                     nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            int   id;
            e = sb_q.pop_front();
            id = tag_q.pop_front();
            chk("pc", id, pc, e.pc);
            chk("icode", id, 64'(icode), 64'(e.icode));
            chk("ifun", id, 64'(ifun), 64'(e.ifun));
            chk("rA", id, 64'(rA), 64'(e.ra));
            chk("rB", id, 64'(rB), 64'(e.rb));
            chk("valC", id, valC, e.valc);
            chk("valP", id, valP, e.valp);
            chk("instr_valid", id, 64'(instr_valid), 64'(e.vld));
            chk("imem_error", id, 64'(imem_error), 64'(e.err));
            chk("stat", id, 64'(stat), 64'(e.stat));
            chk("halted", id, 64'(halted), 64'(e.halted));
            chk("instr_count", id, instr_count, e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] prog [12];

    initial begin
        prog[0] = 8'h30;  prog[1] = 8'hF0;  prog[2] = 8'hEF;
        prog[3] = 8'hCD;  prog[4] = 8'hAB;  prog[5] = 8'h89;
        prog[6] = 8'h67;  prog[7] = 8'h45;  prog[8] = 8'h23;
        prog[9] = 8'h01;  prog[10] = 8'h10; prog[11] = 8'h00;

        reset = 1'b1;
        load_en = 1'b0;
        load_addr = 64'h0;
        load_data = 8'h0;
        pc_updated = 64'h0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) load(64'(i), prog[i]);

        // irmovq decode after reset, memory preserved
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state(1, 64'd0, 4'h3, 4'h0, 4'hF, 4'h0,
                     64'h0123456789ABCDEF, 64'd10, 1'b1, 1'b0,
                     3'd1, 1'b0, 64'd0);

        pc_updated = 64'd10;
        tick();
        expect_state(2, 64'd10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd11, 1'b1, 1'b0, 3'd1, 1'b0, 64'd1);

        // load stall with an out-of-range address
        load_en = 1'b1;
        load_addr = 64'd2000;
        load_data = 8'hC0;
        pc_updated = 64'd11;
        tick();
        expect_state(3, 64'd10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd11, 1'b1, 1'b0, 3'd1, 1'b0, 64'd1);
        tick();
        expect_state(4, 64'd10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd11, 1'b1, 1'b0, 3'd1, 1'b0, 64'd1);
        load_en = 1'b0;

        tick();
        expect_state(5, 64'd11, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd12, 1'b1, 1'b0, 3'd1, 1'b0, 64'd2);

        pc_updated = 64'd99;
        tick();
        expect_state(6, 64'd11, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd12, 1'b1, 1'b0, 3'd2, 1'b1, 64'd3);
        tick();
        expect_state(7, 64'd11, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd12, 1'b1, 1'b0, 3'd2, 1'b1, 64'd3);

        // invalid icode C
        load(64'd0, 8'hC0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state(8, 64'd0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1, 1'b0, 1'b0, 3'd1, 1'b0, 64'd0);
        tick();
        expect_state(9, 64'd0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1, 1'b0, 1'b0, 3'd4, 1'b1, 64'd0);

        // OPq with illegal ifun 5
        load(64'd0, 8'h65);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state(10, 64'd0, 4'h6, 4'h5, 4'hF, 4'h0, 64'h0,
                     64'd1, 1'b0, 1'b0, 3'd1, 1'b0, 64'd0);
        tick();
        expect_state(11, 64'd0, 4'h6, 4'h5, 4'hF, 4'h0, 64'h0,
                     64'd1, 1'b0, 1'b0, 3'd4, 1'b1, 64'd0);

        // jmp straddling the end of memory
        load(64'd0, 8'h10);
        load(64'd1020, 8'h70);
        load(64'd1021, 8'h00);
        load(64'd1022, 8'h00);
        load(64'd1023, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state(12, 64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1, 1'b1, 1'b0, 3'd1, 1'b0, 64'd0);
        pc_updated = 64'd1020;
        tick();
        expect_state(13, 64'd1020, 4'h7, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1029, 1'b1, 1'b1, 3'd1, 1'b0, 64'd1);
        tick();
        expect_state(14, 64'd1020, 4'h7, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1029, 1'b1, 1'b1, 3'd3, 1'b1, 64'd1);

        // write at IMEM_BYTES must not alias onto byte 0
        load(64'd1024, 8'hC0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state(15, 64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,
                     64'd1, 1'b1, 1'b0, 3'd1, 1'b0, 64'd0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        if (checks < 12) begin
            failures++;
            $display("FAIL count actual=%0d required=12", checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_reg.md
Name: fetch_pc_reg

Overview:
- Fetch stage of the SEQ Y86-64 processor. Sits directly downstream of the PC-update stage and consumes its pc_updated output.
- Holds the architectural PC register and the byte-addressed instruction memory. Decodes the instruction at PC into icode/ifun/rA/rB/valC/valP for decode/execute.
- Tracks processor status (AOK/HLT/ADR/INS) and freezes the machine once the status leaves AOK.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes; valid addresses are 0..IMEM_BYTES-1.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
load_en  input  1  program-load write strobe
load_addr  input  64  byte address for load write
load_data  input  8  byte to write
pc_updated  input  64  next PC from the PC-update stage
pc  output  64  current PC register
icode  output  4  high nibble of byte at pc
ifun  output  4  low nibble of byte at pc
rA  output  4  register specifier A; 4'hF when the instruction has no register byte
rB  output  4  register specifier B; 4'hF when the instruction has no register byte
valC  output  64  constant word, little-endian; 0 when the instruction has none
valP  output  64  pc + instruction length
instr_valid  output  1  icode/ifun combination is legal
imem_error  output  1  some byte of the instruction lies outside memory
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  output  1  stat != AOK
instr_count  output  64  number of instructions retired since reset

Behaviour:
- Decode (combinational from pc and memory):
  - Lengths: halt 1, nop 1, cmovXX 2, irmovq 10, rmmovq 10, mrmovq 10, OPq 2, jXX 9, call 9, ret 1, pushq 2, popq 2.
  - Invalid instructions have length 1.
  - Legal ifun: icode 2 and 7 allow 0-6; icode 6 allows 0-3; all other legal icodes (0-B) require ifun 0. icode C-F is invalid.
  - Register byte is at pc+1 for icodes 2, 3, 4, 5, 6, A, B: rA = high nibble, rB = low nibble.
  - valC comes from bytes pc+2..pc+9 for icodes 3, 4, 5, and from bytes pc+1..pc+8 for icodes 7, 8; least-significant byte first.
  - valP = pc + length, modulo 2^64.
  - imem_error = 1 if any address in pc..pc+length-1 is >= IMEM_BYTES. Out-of-range bytes read as 8'h00.
- Reset, at a clock edge with reset=1: pc=0, stat=AOK, instr_count=0. Memory contents are preserved.
- Load: at an edge with load_en=1, mem[load_addr] <= load_data when load_addr < IMEM_BYTES; otherwise the write is ignored.
  - The write occurs even if reset=1 or stat != AOK.
  - While load_en=1, pc, stat and instr_count hold (stall).
- Clock edge with reset=0, load_en=0, stat=AOK. Status priority, first match wins:
  - imem_error -> stat=ADR, pc held.
  - !instr_valid -> stat=INS, pc held.
  - icode==0 (halt) -> stat=HLT, pc held, instr_count += 1.
  - Otherwise -> pc <= pc_updated, instr_count += 1.
- Stat != AOK: pc, stat and instr_count are frozen until reset. Decode outputs keep reflecting the frozen pc.
- Latency: the new pc and its decode are visible one cycle after pc_updated is sampled.
- instr_count wraps at 2^64.

Test Plan:
1. Assert reset for 1 edge -> pc=0, stat=1, halted=0, instr_count=0; memory bytes loaded before reset are unchanged.
2. Load bytes 30 F0 EF CD AB 89 67 45 23 01 at address 0, then reset -> icode=3, ifun=0, rA=F, rB=0, valC=0x0123456789ABCDEF, valP=10, instr_valid=1.
3. Drive pc_updated=10 with byte 10 = 10 (nop) -> after the edge pc=10, icode=1, valP=11, instr_count=1. Holding load_en=1 for 2 cycles keeps pc=10.
4. Byte 11 = 00 and pc_updated=11 -> pc=11. Next edge with pc_updated=99 -> stat=2, halted=1, pc stays 11, instr_count=3.
5. Reset with byte 0 = C0 -> instr_valid=0, valP=1. After the edge stat=4 and pc stays 0. Byte 0 = 65 also gives stat=4.
6. Byte 70 (jmp) at IMEM_BYTES-4, pc steered there -> imem_error=1, and after the edge stat=3 with pc frozen. Writes with load_addr >= IMEM_BYTES have no effect.
